adder_4bit: RTL and testbench

- 4-bit binary adder with carry-in and carry-out, used as a basic arithmetic leaf cell.
- Primary Sum/Cout outputs are purely combinational from A, B, Cin, with no clock dependency.
- A one-stage registered copy of the result, with a valid flag, is provided for pipelined consumers.
- Clocked section uses a single clock with asynchronous active-low reset.

---
 rtl/adder_4bit_pkg.sv | 13 +
 rtl/adder_4bit_if.sv | 35 +++
 rtl/adder_4bit_full_adder.sv | 16 +
 rtl/adder_4bit.sv | 68 ++++++
 tb/tb_adder_4bit.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/adder_4bit_pkg.sv
// rtl/adder_4bit_pkg.sv - shared width, word and registered-result types for adder_4bit
package adder_4bit_pkg;

    localparam int ADD_W = 4;

    typedef logic [ADD_W-1:0] add_word_t;

    typedef struct packed {
        add_word_t sum;
        logic      cout;
    } add_res_t;

endpackage

// File: rtl/adder_4bit_if.sv
// rtl/adder_4bit_if.sv - operand/result bundle for adder_4bit; ovf/ovf_q present under ADDER_4BIT_OVF_EN
interface adder_4bit_if #(
    parameter int WIDTH = adder_4bit_pkg::ADD_W
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             in_valid;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid;
`ifdef ADDER_4BIT_OVF_EN
    logic             ovf;
    logic             ovf_q;
`endif

    modport master (
        output A, B, Cin, in_valid,
`ifdef ADDER_4BIT_OVF_EN
        input  ovf, ovf_q,
`endif
        input  Sum, Cout, sum_q, cout_q, out_valid
    );

    modport slave (
        input  A, B, Cin, in_valid,
`ifdef ADDER_4BIT_OVF_EN
        output ovf, ovf_q,
`endif
        output Sum, Cout, sum_q, cout_q, out_valid
    );

endinterface

// File: rtl/adder_4bit_full_adder.sv
// rtl/adder_4bit_full_adder.sv - single-bit full adder cell of the ripple chain
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_p;

    assign w_p    = i_a ^ i_b;
    assign o_s    = w_p ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/adder_4bit.sv
// rtl/adder_4bit.sv - ripple-carry adder with combinational result and one registered copy; ADDER_4BIT_OVF_EN adds signed overflow
module adder_4bit
    import adder_4bit_pkg::*;
#(
    parameter int WIDTH = ADD_W
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_4bit_if.slave    bus
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    add_res_t         r_res;
    logic             r_valid;

    assign w_carry[0] = bus.Cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        full_adder u_fa (
            .i_a    (bus.A[gi]),
            .i_b    (bus.B[gi]),
            .i_cin  (w_carry[gi]),
            .o_s    (w_sum[gi]),
            .o_cout (w_carry[gi+1])
        );
    end

    // Combinational outputs never depend on the clocked path.
    assign bus.Sum  = w_sum;
    assign bus.Cout = w_carry[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_res.sum  <= w_sum;
                r_res.cout <= w_carry[WIDTH];
            end
        end
    end

    assign bus.sum_q     = r_res.sum;
    assign bus.cout_q    = r_res.cout;
    assign bus.out_valid = r_valid;

`ifdef ADDER_4BIT_OVF_EN
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (bus.in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.ovf   = w_ovf;
    assign bus.ovf_q = r_ovf;
`endif

endmodule

// File: tb/tb_adder_4bit.sv
// tb/tb_adder_4bit.sv - self-checking bench for adder_4bit (vector table, sweep, random model, reset sequences)
module tb_adder_4bit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_failed;

    adder_4bit_if #(.WIDTH(4)) bus ();

    adder_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int cin;
        int exp_sum;
        int exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input int cin, input int v);
        bus.A        = 4'(a);
        bus.B        = 4'(b);
        bus.Cin      = 1'(cin);
        bus.in_valid = 1'(v);
    endtask

    int m_sum;
    int m_cout;
    int m_valid;
    int total;
    int ra, rb, rc, rv;

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst_n    = 1'b0;
        drive(0, 0, 0, 0);

        // Combinational table, applied while reset is held.
        vecs[0] = '{1, 2, 0, 3, 0};
        vecs[1] = '{15, 1, 0, 0, 1};
        vecs[2] = '{15, 15, 1, 15, 1};
        vecs[3] = '{0, 0, 1, 1, 0};
        vecs[4] = '{0, 0, 0, 0, 0};
        vecs[5] = '{10, 7, 0, 1, 1};
        vecs[6] = '{7, 1, 0, 8, 0};
        vecs[7] = '{8, 8, 0, 0, 1};
        #1;
        check("reset_sum_q", int'(bus.sum_q), 0);
        check("reset_cout_q", int'(bus.cout_q), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, 0);
            #10;
            check($sformatf("tbl%0d_sum", i), int'(bus.Sum), vecs[i].exp_sum);
            check($sformatf("tbl%0d_cout", i), int'(bus.Cout), vecs[i].exp_cout);
        end

        // Exhaustive sweep against integer addition.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive(a, b, c, 0);
                    #1;
                    check($sformatf("sweep_%0d_%0d_%0d", a, b, c),
                          int'({bus.Cout, bus.Sum}), a + b + c);
                end
            end
        end

`ifdef ADDER_4BIT_OVF_EN
        drive(7, 1, 0, 0);
        #1;
        check("ovf_7p1", int'(bus.ovf), 1);
        drive(8, 8, 0, 0);
        #1;
        check("ovf_8p8", int'(bus.ovf), 1);
        check("ovf_8p8_cout", int'(bus.Cout), 1);
        drive(3, 2, 0, 0);
        #1;
        check("ovf_3p2", int'(bus.ovf), 0);
        check("reset_ovf_q", int'(bus.ovf_q), 0);
`endif

        // Registered path: capture then hold.
        @(negedge clk);
        rst_n = 1'b1;
        drive(10, 7, 0, 1);
        @(posedge clk); #1;
        check("cap_sum_q", int'(bus.sum_q), 1);
        check("cap_cout_q", int'(bus.cout_q), 1);
        check("cap_out_valid", int'(bus.out_valid), 1);
        @(negedge clk);
        drive(3, 3, 0, 0);
        @(posedge clk); #1;
        check("hold_out_valid", int'(bus.out_valid), 0);
        check("hold_sum_q", int'(bus.sum_q), 1);
        check("hold_cout_q", int'(bus.cout_q), 1);

        // Reset pulse after in_valid is presented, held across the edge.
        @(negedge clk);
        drive(5, 6, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum_q", int'(bus.sum_q), 0);
        check("async_rst_cout_q", int'(bus.cout_q), 0);
        check("async_rst_out_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        check("rst_edge_out_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(5, 6, 0, 0);
        @(posedge clk); #1;
        check("post_rst_out_valid", int'(bus.out_valid), 0);
        check("post_rst_sum_q", int'(bus.sum_q), 0);

        // Random registered stream against a hold-last-valid model.
        m_sum   = 0;
        m_cout  = 0;
        m_valid = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ra = int'($urandom_range(15, 0));
            rb = int'($urandom_range(15, 0));
            rc = int'($urandom_range(1, 0));
            rv = int'($urandom_range(1, 0));
            drive(ra, rb, rc, rv);
            #1;
            total = ra + rb + rc;
            check($sformatf("rnd%0d_sum", i), int'(bus.Sum), total % 16);
            check($sformatf("rnd%0d_cout", i), int'(bus.Cout), total / 16);
            @(posedge clk); #1;
            m_valid = rv;
            if (rv == 1) begin
                m_sum  = total % 16;
                m_cout = total / 16;
            end
            check($sformatf("rnd%0d_sum_q", i), int'(bus.sum_q), m_sum);
            check($sformatf("rnd%0d_cout_q", i), int'(bus.cout_q), m_cout);
            check($sformatf("rnd%0d_out_valid", i), int'(bus.out_valid), m_valid);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
